// File: rtl/dcmac_0_ts_context_mem_v3_if.sv
// Request/response bundle for the DCMAC TS per-channel context store.
// DCMAC_TS_CTX_PARITY_EN adds the o_par_err response bit.
interface dcmac_0_ts_context_mem_v3_if #(
  parameter int ID_W = 3,
  parameter int DW   = 32
);
  logic            ts_rst;
  logic [ID_W-1:0] i_rd_id;
  logic            i_rd_vld;
  logic [ID_W-1:0] i_wr_id;
  logic            i_wr_ena;
  logic [DW-1:0]   i_wr_dat;
  logic [DW-1:0]   o_dat;
  logic            o_vld;
  logic            o_init;
  logic            o_wr_drop;
`ifdef DCMAC_TS_CTX_PARITY_EN
  logic            o_par_err;
`endif

  modport master (
    output ts_rst, i_rd_id, i_rd_vld, i_wr_id, i_wr_ena, i_wr_dat,
    input  o_dat, o_vld, o_init, o_wr_drop
`ifdef DCMAC_TS_CTX_PARITY_EN
    , input o_par_err
`endif
  );

  modport slave (
    input  ts_rst, i_rd_id, i_rd_vld, i_wr_id, i_wr_ena, i_wr_dat,
    output o_dat, o_vld, o_init, o_wr_drop
`ifdef DCMAC_TS_CTX_PARITY_EN
    , output o_par_err
`endif
  );
endinterface

// File: rtl/dcmac_0_ts_context_mem_v3.sv
// Per-channel timestamp context store: init sweep, write-first reads, overwrite/accumulate.
// Optional even parity per entry with DCMAC_TS_CTX_PARITY_EN.
module dcmac_0_ts_context_mem_v3 #(
  parameter int            NUM_ID     = 6,
  parameter int            DW         = 32,
  parameter logic [DW-1:0] INIT_VALUE = '0,
  parameter int            RD_LAT     = 1,
  parameter int            MODE       = 0,
  localparam int           ID_W       = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input logic clk,
  input logic rst,
  dcmac_0_ts_context_mem_v3_if.slave bus
);
`ifdef DCMAC_TS_CTX_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t          r_state;
  logic            r_init;
  logic [ID_W-1:0] r_ptr;
  logic [MW-1:0]   r_mem [NUM_ID];
  logic            r_wr_drop;
  logic            r_s1_vld;
  logic [DW-1:0]   r_s1_dat;

  logic          w_rd_in, w_wr_in, w_same_id, w_ts_hit, w_wr_ok, w_drop;
  logic [DW-1:0] w_wr_old, w_wr_val, w_rd_dat;
  logic [MW-1:0] w_rd_mem;
  logic [NUM_ID-1:0] w_we;
  logic [MW-1:0]     w_wd [NUM_ID];

  function automatic logic [MW-1:0] f_enc(input logic [DW-1:0] d);
`ifdef DCMAC_TS_CTX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign w_rd_in   = 32'(bus.i_rd_id) < NUM_ID;
  assign w_wr_in   = 32'(bus.i_wr_id) < NUM_ID;
  assign w_same_id = bus.i_rd_id == bus.i_wr_id;
  assign w_ts_hit  = bus.ts_rst && !r_init && w_rd_in;
  // ts_rst owns the entry when both target the same ID
  assign w_wr_ok   = bus.i_wr_ena && !r_init && w_wr_in && !(bus.ts_rst && w_same_id);
  assign w_drop    = (bus.i_wr_ena && !w_wr_ok) || (bus.ts_rst && r_init);
  assign w_wr_old  = w_wr_in ? r_mem[bus.i_wr_id][DW-1:0] : '0;
  assign w_wr_val  = (MODE == 1) ? w_wr_old + bus.i_wr_dat : bus.i_wr_dat;
  assign w_rd_mem  = w_rd_in ? r_mem[bus.i_rd_id] : '0;

  generate
    for (genvar gi = 0; gi < NUM_ID; gi++) begin : g_ent
      logic w_sw_hit, w_ts_ent, w_wr_ent;
      assign w_sw_hit = r_init && (32'(r_ptr) == gi);
      assign w_ts_ent = w_ts_hit && (32'(bus.i_rd_id) == gi);
      assign w_wr_ent = w_wr_ok && (32'(bus.i_wr_id) == gi);
      assign w_we[gi] = w_sw_hit || w_ts_ent || w_wr_ent;
      assign w_wd[gi] = (r_init || w_ts_ent) ? f_enc(INIT_VALUE) : f_enc(w_wr_val);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ID; k++) begin
      if (w_we[k]) r_mem[k] <= w_wd[k];
    end
  end

  // Same-cycle updates are folded in so the read reflects its own issue cycle
  assign w_rd_dat = (r_init || !w_rd_in || w_ts_hit) ? INIT_VALUE :
                    (w_wr_ok && w_same_id)          ? w_wr_val   : w_rd_mem[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SWEEP;
      r_init  <= 1'b1;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          if (32'(r_ptr) == NUM_ID - 1) begin
            r_state <= ST_RUN;
            r_init  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: r_init <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_drop <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_dat  <= '0;
    end else begin
      r_wr_drop <= w_drop;
      r_s1_vld  <= bus.i_rd_vld;
      if (bus.i_rd_vld) r_s1_dat <= w_rd_dat;
    end
  end

  assign bus.o_init    = r_init;
  assign bus.o_wr_drop = r_wr_drop;

`ifdef DCMAC_TS_CTX_PARITY_EN
  logic w_rd_fwd, w_rd_perr, r_s1_perr;
  assign w_rd_fwd  = r_init || !w_rd_in || w_ts_hit || (w_wr_ok && w_same_id);
  assign w_rd_perr = !w_rd_fwd && (^w_rd_mem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s1_perr <= 1'b0;
    else     r_s1_perr <= bus.i_rd_vld && w_rd_perr;
  end
`endif

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          r_s2_vld;
      logic [DW-1:0] r_s2_dat;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_vld <= 1'b0;
          r_s2_dat <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) r_s2_dat <= r_s1_dat;
        end
      end
      assign bus.o_vld = r_s2_vld;
      assign bus.o_dat = r_s2_dat;
`ifdef DCMAC_TS_CTX_PARITY_EN
      logic r_s2_perr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_s2_perr <= 1'b0;
        else     r_s2_perr <= r_s1_perr;
      end
      assign bus.o_par_err = r_s2_perr;
`endif
    end else begin : g_lat1
      assign bus.o_vld = r_s1_vld;
      assign bus.o_dat = r_s1_dat;
`ifdef DCMAC_TS_CTX_PARITY_EN
      assign bus.o_par_err = r_s1_perr;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_dcmac_0_ts_context_mem_v3.sv
// Bench for dcmac_0_ts_context_mem_v3: two configs driven in lockstep against an array model.
// Parity checks compile only with DCMAC_TS_CTX_PARITY_EN.
module tb_dcmac_0_ts_context_mem_v3;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   verbose  = 1'b1;
  bit   model_en = 1'b1;

  always #5 clk = ~clk;

  dcmac_0_ts_context_mem_v3_if #(.ID_W(3), .DW(32)) b0 ();
  dcmac_0_ts_context_mem_v3_if #(.ID_W(3), .DW(8))  b1 ();

  dcmac_0_ts_context_mem_v3 #(.NUM_ID(N), .DW(32), .INIT_VALUE(32'h5A), .RD_LAT(2), .MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  dcmac_0_ts_context_mem_v3 #(.NUM_ID(N), .DW(8), .INIT_VALUE(8'hFF), .RD_LAT(1), .MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Reference: entry contents, sweep progress and expected registered outputs
  logic [31:0] cfg_init [2];
  logic [31:0] cfg_mask [2];
  bit          cfg_mode [2];
  int          cfg_lat  [2];
  logic [31:0] m_mem [2][N];
  int          swp;
  bit          e_init;
  bit          e_vld  [2];
  logic [31:0] e_dat  [2];
  bit          e_drop [2];
  bit          p_v    [2];
  logic [31:0] p_d    [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    swp    = 0;
    e_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e_vld[k] = 1'b0; e_dat[k] = '0; e_drop[k] = 1'b0;
      p_v[k] = 1'b0;   p_d[k] = '0;
      for (int i = 0; i < N; i++) m_mem[k][i] = cfg_init[k];
    end
  endtask

  task automatic compare_outputs();
    if (!model_en) return;
    check("d0_vld",  64'(b0.o_vld),     64'(e_vld[0]));
    check("d0_dat",  64'(b0.o_dat),     64'(e_dat[0]));
    check("d0_init", 64'(b0.o_init),    64'(e_init));
    check("d0_drop", 64'(b0.o_wr_drop), 64'(e_drop[0]));
    check("d1_vld",  64'(b1.o_vld),     64'(e_vld[1]));
    check("d1_dat",  64'(b1.o_dat),     64'(e_dat[1][7:0]));
    check("d1_init", 64'(b1.o_init),    64'(e_init));
    check("d1_drop", 64'(b1.o_wr_drop), 64'(e_drop[1]));
`ifdef DCMAC_TS_CTX_PARITY_EN
    check("d0_perr", 64'(b0.o_par_err), 64'd0);
    check("d1_perr", 64'(b1.o_par_err), 64'd0);
`endif
  endtask

  task automatic step(input bit r, input bit rv, input logic [2:0] rid, input bit ts,
                      input bit we, input logic [2:0] wid, input logic [31:0] wd);
    bit          init, conflict, drop, ov;
    logic [31:0] rdv, od;
    @(negedge clk);
    compare_outputs();
    rst = r;
    b0.i_rd_vld = rv; b0.i_rd_id = rid; b0.ts_rst = ts;
    b0.i_wr_ena = we; b0.i_wr_id = wid; b0.i_wr_dat = wd;
    b1.i_rd_vld = rv; b1.i_rd_id = rid; b1.ts_rst = ts;
    b1.i_wr_ena = we; b1.i_wr_id = wid; b1.i_wr_dat = wd[7:0];
    if (verbose)
      $display("txn t=%0t rst=%0b rd=%0b/%0d ts=%0b wr=%0b/%0d/0x%0h", $time, r, rv, rid, ts, we, wid, wd);
    if (r) begin
      model_reset();
    end else begin
      init     = swp < N;
      conflict = ts && we && (rid == wid);
      drop     = (we && (init || wid >= N || conflict)) || (ts && init);
      for (int k = 0; k < 2; k++) begin
        if (!init) begin
          if (ts && rid < N) m_mem[k][rid] = cfg_init[k];
          if (we && wid < N && !conflict)
            m_mem[k][wid] = cfg_mode[k] ? ((m_mem[k][wid] + wd) & cfg_mask[k]) : (wd & cfg_mask[k]);
        end
        rdv = (init || rid >= N) ? cfg_init[k] : m_mem[k][rid];
        if (cfg_lat[k] == 1) begin
          ov = rv; od = rdv;
        end else begin
          ov = p_v[k]; od = p_d[k];
          p_v[k] = rv; p_d[k] = rdv;
        end
        e_vld[k]  = ov;
        if (ov) e_dat[k] = od;
        e_drop[k] = drop;
      end
      if (init) swp++;
      e_init = swp < N;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] id);
    step(1'b0, 1'b1, id, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    int hi0, hi1;
    cfg_init = '{32'h5A, 32'hFF};
    cfg_mask = '{32'hFFFF_FFFF, 32'hFF};
    cfg_mode = '{1'b0, 1'b1};
    cfg_lat  = '{2, 1};
    {b0.ts_rst, b0.i_rd_vld, b0.i_rd_id, b0.i_wr_ena, b0.i_wr_id, b0.i_wr_dat} = '0;
    {b1.ts_rst, b1.i_rd_vld, b1.i_rd_id, b1.i_wr_ena, b1.i_wr_id, b1.i_wr_dat} = '0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;

    // Reset, partial sweep with a dropped write, reset again at entry 3
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 32'd0);
    idle();
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 32'd9);
    rd(3'd1);
    check("sweep_wr_drop", 64'(b0.o_wr_drop), 64'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);

    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 9; i++) begin
      rd(3'(i % 8));
      if (b0.o_init) hi0++;
      if (b1.o_init) hi1++;
    end
    check("init_len_d0", 64'(hi0), 64'd6);
    check("init_len_d1", 64'(hi1), 64'd6);

    for (int i = 0; i < N; i++) rd(3'(i));
    rd(3'd4);
    idle();
    check("id4_d1", 64'(b1.o_dat), 64'h0FF);
    idle();
    check("id4_d0", 64'(b0.o_dat), 64'h5A);

    // Write ID3 then read it in the same and following two cycles
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 32'h1234);
    rd(3'd3);
    rd(3'd3);
    check("fwd_t0_vld", 64'(b0.o_vld), 64'd1);
    check("fwd_t0_dat", 64'(b0.o_dat), 64'h1234);
    idle();
    check("fwd_t1_dat", 64'(b0.o_dat), 64'h1234);
    idle();
    check("fwd_t2_dat", 64'(b0.o_dat), 64'h1234);

    // ts_rst and write hit ID2 together
    step(1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2, 32'd7);
    rd(3'd2);
    check("conf_drop_d0", 64'(b0.o_wr_drop), 64'd1);
    check("conf_drop_d1", 64'(b1.o_wr_drop), 64'd1);
    idle();
    check("conf_drop_once", 64'(b0.o_wr_drop), 64'd0);
    check("conf_d1_dat", 64'(b1.o_dat), 64'h0FF);
    idle();
    check("conf_d0_dat", 64'(b0.o_dat), 64'h5A);

    // 100 back-to-back accumulates on ID1, then an 8-bit wrap
    verbose = 1'b0;
    step(1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 32'd1);
    verbose = 1'b1;
    rd(3'd1);
    idle();
    check("acc100_d1", 64'(b1.o_dat), 64'h63);
    step(1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 32'd2);
    rd(3'd1);
    idle();
    check("acc_wrap_d1", 64'(b1.o_dat), 64'h01);

    // Random traffic with occasional resets
    verbose = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 8; i++) idle();

`ifdef DCMAC_TS_CTX_PARITY_EN
    verbose  = 1'b1;
    model_en = 1'b0;
    dut0.r_mem[0][0] = ~dut0.r_mem[0][0];
    rd(3'd0);
    idle();
    idle();
    check("par_err_id0", 64'(b0.o_par_err), 64'd1);
    check("par_vld_id0", 64'(b0.o_vld), 64'd1);
    rd(3'd1);
    idle();
    idle();
    check("par_ok_id1", 64'(b0.o_par_err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
